// File: rtl/lcd_arbiter_if.sv
// rtl/lcd_arbiter_if.sv - requester and LCD driver byte bus shared by lcd_arbiter
//   req0_*  : command/config byte port (valid, data, dcx, last, ready)
//   req1_*  : pixel-stream byte port   (valid, data, dcx, last, ready)
//   lcd_*   : driver side (data_in, data_dcx, start, done)
//   slave   : arbiter view; master : requesters + driver view
interface lcd_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_dcx;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_dcx;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] lcd_data_in;
    logic       lcd_data_dcx;
    logic       lcd_start;
    logic       lcd_done;

    modport slave (
        input  req0_valid, req0_data, req0_dcx, req0_last,
        input  req1_valid, req1_data, req1_dcx, req1_last,
        input  lcd_done,
        output req0_ready, req1_ready,
        output lcd_data_in, lcd_data_dcx, lcd_start
    );

    modport master (
        output req0_valid, req0_data, req0_dcx, req0_last,
        output req1_valid, req1_data, req1_dcx, req1_last,
        output lcd_done,
        input  req0_ready, req1_ready,
        input  lcd_data_in, lcd_data_dcx, lcd_start
    );
endinterface

// File: rtl/lcd_arbiter.sv
// rtl/lcd_arbiter.sv - two-port byte arbiter in front of the lcd_driver with burst lock and done watchdog
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : lcd_arbiter_if.slave (requester ports 0/1 and driver handshake)
//   owner        : requester of the current or locked byte
//   locked       : a burst is open, only owner may be granted
//   idle         : IDLE state, no lock, no valid input
//   timeout_err  : sticky watchdog flag, err_clr clears it (set wins)
module lcd_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_arbiter_if.slave       bus,
    output logic               owner,
    output logic               locked,
    output logic               idle,
    output logic               timeout_err,
    input  logic               err_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] wd;
    logic          p1_skip;
    logic          grant0;
    logic          grant1;

    // While a burst is open only the owner is eligible. Unlocked, port 0 wins
    // unless port 1 lost the previous contested arbitration.
    assign grant1 = bus.req1_valid && (locked ? owner : (!bus.req0_valid || p1_skip));
    assign grant0 = bus.req0_valid && (locked ? !owner : !grant1);

    assign idle = (state == IDLE) && !locked && !bus.req0_valid && !bus.req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wd               <= '0;
            p1_skip          <= 1'b0;
            owner            <= 1'b0;
            locked           <= 1'b0;
            timeout_err      <= 1'b0;
            bus.req0_ready   <= 1'b0;
            bus.req1_ready   <= 1'b0;
            bus.lcd_data_in  <= 8'h00;
            bus.lcd_data_dcx <= 1'b0;
            bus.lcd_start    <= 1'b0;
        end else begin
            bus.req0_ready <= 1'b0;
            bus.req1_ready <= 1'b0;
            bus.lcd_start  <= 1'b0;
            // Clear first so a watchdog set later in this block overrides it.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant0) begin
                        bus.req0_ready   <= 1'b1;
                        bus.lcd_data_in  <= bus.req0_data;
                        bus.lcd_data_dcx <= bus.req0_dcx;
                        owner            <= 1'b0;
                        locked           <= !bus.req0_last;
                        state            <= ISSUE;
                        if (bus.req1_valid) begin
                            p1_skip <= 1'b1;
                        end
                    end else if (grant1) begin
                        bus.req1_ready   <= 1'b1;
                        bus.lcd_data_in  <= bus.req1_data;
                        bus.lcd_data_dcx <= bus.req1_dcx;
                        owner            <= 1'b1;
                        locked           <= !bus.req1_last;
                        p1_skip          <= 1'b0;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.lcd_start <= 1'b1;
                    wd            <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.lcd_done) begin
                        state <= IDLE;
                    end else if (wd == TW'(TIMEOUT - 1)) begin
                        // Byte is dropped; the lock is released so the bus cannot wedge.
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_arbiter.md
# lcd_arbiter

Shares the single `lcd_driver` byte port between two requesters: port 0 carries command/config bytes (init, window set, from `mmap_interface`), port 1 carries pixel-stream bytes (line flushes). It latches one byte per grant, pulses `lcd_start`, waits for `lcd_done`, and locks the grant to a requester for a whole burst so pixel data is never interleaved with commands. It also flags a stalled driver with a `done` watchdog and exposes an `idle` status for the upstream busy pin.

## Interface
- `TIMEOUT`, 1024: cycles in WAIT_DONE before a watchdog abort; minimum 2.
- `TW`, 11: watchdog counter width; must satisfy 2^TW > TIMEOUT.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  requester has a byte.
- `req0_data` / `req1_data`  in  8  byte.
- `req0_dcx` / `req1_dcx`  in  1  1 = data, 0 = command.
- `req0_last` / `req1_last`  in  1  byte ends the requester's burst and releases the lock.
- `req0_ready` / `req1_ready`  out  1  one-cycle accept pulse.
- `lcd_data_in`  out  8  byte to driver.
- `lcd_data_dcx`  out  1  dcx to driver.
- `lcd_start`  out  1  one-cycle start pulse.
- `lcd_done`  in  1  driver completion pulse.
- `owner`  out  1  requester of the current or locked byte.
- `locked`  out  1  a burst is open.
- `idle`  out  1  IDLE state, no lock, no valid input.
- `timeout_err`  out  1  sticky watchdog flag.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, arbitration:
  - If `locked`, only `owner` is eligible; the other port's valid is ignored.
  - If not locked, port 0 has priority. Exception: if port 1 was starved last time (flag `p1_skip`, set when port 1 is valid but loses), port 1 wins the next unlocked arbitration.
  - On a grant: assert that port's `ready` for this cycle; latch data, dcx and last into output registers; set `owner`. Set `locked` = !last; clear `locked` when last = 1. Go to ISSUE.
- ISSUE: `lcd_start` = 1 for exactly one cycle; clear the watchdog counter; go to WAIT_DONE.
- WAIT_DONE: increment the watchdog each cycle.
  - `lcd_done` → IDLE.
  - Watchdog reaches TIMEOUT-1 without `done` → set `timeout_err`, clear `locked`, go to IDLE. The byte is dropped and there is no retry.
- `lcd_data_in` and `lcd_data_dcx` hold the latched value from ISSUE through WAIT_DONE and until the next grant.
- A `lcd_done` received in IDLE or ISSUE is ignored.
- `err_clr` clears `timeout_err`. If `err_clr` and a set event occur in the same cycle, set wins.
- Reset mid-operation drops the in-flight byte. A driver already started finishes on its own; its later `done` is ignored.

## Timing
- All outputs reset to 0: `req*_ready`, `lcd_data_in` = 8'h00, `lcd_data_dcx`, `lcd_start`, `owner`, `locked`, `timeout_err`. The state resets to IDLE.
- `idle` is combinational from state, `locked` and the valids. It reads 1 out of reset once the valids are low.
- Accept in cycle N → `lcd_start` in N+1 → `done` in cycle D → earliest next accept in D+1. The per-byte overhead is 2 cycles plus the driver latency.
- Ready is a registered pulse issued only in IDLE. A requester must hold valid, data, dcx and last stable until it sees ready.
- Watchdog abort: `timeout_err` is set at cycle N+1+TIMEOUT; the state is IDLE on the following cycle.

## Test plan
- Single command: `req0` 8'h2A with dcx=0, last=1; the driver returns `done` 5 cycles after start. Required: ready at N, `lcd_start` at N+1 with data 8'h2A and dcx 0, back to IDLE at N+7, `idle`=1.
- Burst lock: `req1` sends 4 bytes (last on the 4th) while `req0` is valid from the 2nd byte. Required: all 4 port-1 bytes go out in order before `req0` is granted; `locked`=1 until the 4th accept.
- Simultaneous, unlocked: both ports valid with last=1 on every byte. Required: grants alternate 0, 1, 0, 1 via `p1_skip`; no port waits more than one byte.
- Watchdog: TIMEOUT=16, the driver never sends `done`. Required: `timeout_err`=1 at N+17, lock cleared, next request accepted. `err_clr` then clears the flag; `err_clr` held during a second timeout leaves the flag at 1.
- Stray done: a `lcd_done` pulse in IDLE is ignored (no state change). A later byte still requires its own `done`.
- Async reset: assert `rst_n` low in WAIT_DONE during a locked burst. Required: all outputs are 0 immediately without a clock edge, and the first request after release is arbitrated unlocked.
